cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

- Shares the two common-data-bus (CDB) broadcast ports between up to NREQ result producers (ALU and load units).
- Each producer gets a one-entry holding register, so a finished result never has to stall inside its unit.
- Arbitration is round-robin; up to two winners are driven onto registered CDB outputs each cycle.
- Sits between the execution units and the wakeup inputs of the arithmetic and load/store reservation stations and the RAT.

## Interface
- NREQ, 4, number of result producers (2..8)
- TAGW, 5, rename tag width
- DATAW, 32, result width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of all held and outgoing results
- req_valid  in  NREQ  producer i presents a result
- req_wr  in  NREQ  result writes a register; 0 means there is nothing to broadcast
- req_tag  in  NREQ*TAGW  destination tag, producer i at bits [i*TAGW +: TAGW]
- req_data  in  NREQ*DATAW  result value, same packing
- req_ready  out  NREQ  holding slot i can accept this cycle
- cdb_valid  out  2  broadcast port p carries a result; drives the *_wr wakeup inputs
- cdb_tag  out  2*TAGW  port p tag at [p*TAGW +: TAGW]
- cdb_data  out  2*DATAW  port p value
- pend  out  NREQ  holding-slot occupancy, for debug and stall logic

## Operation
- **State**
  - Per slot: pend[i], tag, data.
  - rr_ptr: log2(NREQ) bits.
  - Registered CDB outputs.
- **Reset values**
  - pend, cdb_valid = 0; cdb_tag, cdb_data = 0; rr_ptr = 0.
  - req_ready = all ones.
- **Arbitration** (combinational, from registered pend and rr_ptr only)
  - Scan indices rr_ptr, rr_ptr+1, … mod NREQ.
  - The first pending slot found is g0 and goes to port 0; the second is g1 and goes to port 1.
  - At most two grants per cycle.
- **Ready**
  - req_ready[i] = ~pend[i] | grant[i].
  - Ready never depends on req_valid, so there is no combinational loop.
- **Accept** (req_valid[i] & req_ready[i])
  - req_wr[i]=1: pend[i] is set, or stays set if the slot was granted this cycle; tag and data are captured.
  - req_wr[i]=0: the result is consumed and dropped, and pend[i] is not set.
- **Grant**
  - Each granted slot's tag/data is loaded into cdb_tag/cdb_data of its port, and that cdb_valid bit is set.
  - Granted pend bits clear unless a new accept on the same slot refills them in the same cycle.
  - Ports with no winner load cdb_valid=0 and hold their previous tag/data.
- **rr_ptr**
  - If at least one grant: rr_ptr ← (last granted index + 1) mod NREQ.
  - Otherwise rr_ptr holds.
- **flush**
  - At the edge: all pend and cdb_valid clear; req_valid accepts that cycle are discarded.
  - req_ready is unaffected.
  - rr_ptr holds.
- **Tags**
  - Tags are unique under renaming; the block does no duplicate-tag checking.
- **Reset mid-operation**
  - Asynchronous rst drops all outputs to their reset values immediately.
  - Results that were held are lost.

## Timing
- **Latency**
  - A result accepted at edge k is granted in cycle k..k+1.
  - With an empty competition it appears on cdb_valid after edge k+1: one cycle from accept to broadcast.
- **Throughput**
  - Sustained 2 broadcasts per cycle.
  - A producer issuing every cycle is never throttled while at most 2 slots are active.
- **Starvation bound**
  - A pending slot is granted within ceil(NREQ/2) cycles of being set, regardless of other traffic.
- **Simultaneous grant and accept on one slot**
  - The old value broadcasts and the new value is held, with no bubble.
- **Full**
  - With all NREQ slots pending, exactly two are granted per cycle.
  - A producer whose slot is occupied and not granted sees req_ready=0 and must hold its req_* signals.
- **CDB outputs**
  - Outputs are registered, with no combinational path from req_* to cdb_*.
  - Each cdb_valid pulse lasts exactly one cycle per result.

## Test plan
- **Reset:** assert rst low mid-traffic (slots 0 and 2 pending) → pend=0, cdb_valid=0, req_ready=4'b1111 immediately. After release, a single req on slot 1 (tag 5, data 32'hA5) → cdb_valid=2'b01, cdb_tag[4:0]=5, data A5 exactly one cycle after accept.
- **Four-way collision:** all four req_valid with wr=1 at rr_ptr=0 → cycle 1 broadcasts slots 0 and 1 on ports 0/1; cycle 2 broadcasts 2 and 3; rr_ptr=0 afterwards; req_ready=4'b0011 during cycle 1.
- **Fairness:** slots 0, 1, 2 request continuously → grant pairs rotate (0,1), (2,0), (1,2), …; no slot waits more than 2 cycles.
- **Drop:** req on slot 3 with wr=0 → req_ready=1, pend[3] stays 0, no cdb_valid pulse.
- **Back-to-back:** slot 0 presents a new result every cycle (tags 1, 2, 3) while alone → cdb_valid[0] high for three consecutive cycles with tags 1, 2, 3, and req_ready[0] stays 1.
- **Flush:** slots 1 and 2 pending, assert flush for one cycle → next cycle pend=0, cdb_valid=0, and the discarded tags never appear on the CDB.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Purpose : shares two registered CDB broadcast ports among NREQ result producers, with one holding slot per producer.
// Latency : one cycle from accept to broadcast when the slot wins at once; a pending slot wins within ceil(NREQ/2) cycles.
// Backpr. : req_ready[i] = ~pend[i] | grant[i]; a producer whose slot is held and not granted must keep its req_* stable.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   flush               synchronous squash of held slots, outgoing CDB results and same-cycle accepts
//   req_valid/req_wr    per-producer result present / result writes a register (wr=0 is consumed and dropped)
//   req_tag/req_data    per-producer tag and value, producer i at [i*W +: W]
//   req_ready           holding slot i can take a result this cycle
//   cdb_valid/tag/data  two registered broadcast ports, port p at [p*W +: W]
//   pend                holding-slot occupancy
module cdb_arbiter #(
  parameter int NREQ  = 4,
  parameter int TAGW  = 5,
  parameter int DATAW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ*TAGW-1:0]  req_tag,
  input  logic [NREQ*DATAW-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [1:0]            cdb_valid,
  output logic [2*TAGW-1:0]     cdb_tag,
  output logic [2*DATAW-1:0]    cdb_data,
  output logic [NREQ-1:0]       pend
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Holding slots
  logic [NREQ-1:0]  pend_q, pend_d;
  logic [TAGW-1:0]  tag_q  [NREQ];
  logic [TAGW-1:0]  tag_d  [NREQ];
  logic [DATAW-1:0] data_q [NREQ];
  logic [DATAW-1:0] data_d [NREQ];

  // Round-robin pointer: first index scanned next cycle
  logic [PTRW-1:0]  rr_q, rr_d;

  // Registered CDB ports
  logic [1:0]         cdb_valid_q, cdb_valid_d;
  logic [2*TAGW-1:0]  cdb_tag_q, cdb_tag_d;
  logic [2*DATAW-1:0] cdb_data_q, cdb_data_d;

  // Arbitration results
  logic            g0_vld, g1_vld;
  logic [PTRW-1:0] g0_idx, g1_idx;
  logic [PTRW-1:0] scan_idx;
  logic [PTRW-1:0] last_idx;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] accept;

  // Arbitration looks only at registered state, so req_ready never depends
  // on req_valid and there is no combinational path into the CDB registers.
  always_comb begin
    g0_vld   = 1'b0;
    g1_vld   = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PTRW'((int'(rr_q) + k) % NREQ);
      if (pend_q[scan_idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = scan_idx;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (g0_vld) grant[g0_idx] = 1'b1;
    if (g1_vld) grant[g1_idx] = 1'b1;
  end

  // A granted slot empties at this edge, so it may take a new result now.
  assign req_ready = ~pend_q | grant;
  assign accept    = req_valid & req_ready;

  // Slot update: an accept with wr=1 (re)fills the slot; wr=0 consumes the
  // result without occupying the slot. Flush wins over everything.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREQ; i++) begin
      tag_d[i]  = tag_q[i];
      data_d[i] = data_q[i];
      if (flush) begin
        pend_d[i] = 1'b0;
      end else if (accept[i]) begin
        pend_d[i] = req_wr[i];
        if (req_wr[i]) begin
          tag_d[i]  = req_tag[i*TAGW +: TAGW];
          data_d[i] = req_data[i*DATAW +: DATAW];
        end
      end else if (grant[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Pointer moves just past the last winner so both ports rotate fairly.
  always_comb begin
    last_idx = g1_vld ? g1_idx : g0_idx;
    rr_d     = rr_q;
    if (!flush && g0_vld) begin
      rr_d = (last_idx == PTRW'(NREQ - 1)) ? '0 : last_idx + PTRW'(1);
    end
  end

  // CDB ports: winners load tag/data; idle ports keep their last tag/data.
  always_comb begin
    cdb_valid_d = {g1_vld, g0_vld} & {2{~flush}};
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    if (g0_vld) begin
      cdb_tag_d[0 +: TAGW]   = tag_q[g0_idx];
      cdb_data_d[0 +: DATAW] = data_q[g0_idx];
    end
    if (g1_vld) begin
      cdb_tag_d[TAGW +: TAGW]   = tag_q[g1_idx];
      cdb_data_d[DATAW +: DATAW] = data_q[g1_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      rr_q        <= '0;
      cdb_valid_q <= '0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      for (int i = 0; i < NREQ; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      pend_q      <= pend_d;
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      for (int i = 0; i < NREQ; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign pend      = pend_q;
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose : directed self-checking bench for cdb_arbiter (NREQ=4, TAGW=5, DATAW=32).
// Latency : inputs driven 1ns after each rising edge; outputs sampled at the same point.
// Backpr. : producers hold req_* while req_ready is low.
module tb_cdb_arbiter;

  localparam int NREQ  = 4;
  localparam int TAGW  = 5;
  localparam int DATAW = 32;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_wr;
  logic [NREQ*TAGW-1:0]  req_tag;
  logic [NREQ*DATAW-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [1:0]            cdb_valid;
  logic [2*TAGW-1:0]     cdb_tag;
  logic [2*DATAW-1:0]    cdb_data;
  logic [NREQ-1:0]       pend;

  int n_chk;
  int n_pass;

  cdb_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .DATAW(DATAW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .pend      (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int slot, input logic [TAGW-1:0] t, input logic [DATAW-1:0] d);
    req_tag[slot*TAGW +: TAGW]    = t;
    req_data[slot*DATAW +: DATAW] = d;
  endtask

  int exp0[6];
  int exp1[6];

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_tag   = '0;
    req_data  = '0;

    // Reset state
    #3;
    check("rst_pend", 64'(pend), 64'h0);
    check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    check("rst_ready", 64'(req_ready), 64'hF);
    check("rst_cdb_tag", 64'(cdb_tag), 64'h0);
    #9 rst = 1'b1;
    tick();

    // Reset mid-traffic: slots 0 and 2 keep issuing
    req_valid = 4'b0101;
    req_wr    = 4'b0101;
    set_req(0, 5'd10, 32'h10);
    set_req(2, 5'd12, 32'h12);
    tick();
    check("mt_pend", 64'(pend), 64'h5);
    tick();
    check("mt_cdb_valid", 64'(cdb_valid), 64'h3);
    #2 rst = 1'b0;
    #1;
    check("mt_rst_pend", 64'(pend), 64'h0);
    check("mt_rst_cdb_valid", 64'(cdb_valid), 64'h0);
    check("mt_rst_ready", 64'(req_ready), 64'hF);
    req_valid = '0;
    req_wr    = '0;
    #2 rst = 1'b1;
    tick();

    // Single request on slot 1
    req_valid = 4'b0010;
    req_wr    = 4'b0010;
    set_req(1, 5'd5, 32'hA5);
    tick();
    req_valid = '0;
    check("single_pend", 64'(pend), 64'h2);
    check("single_no_early", 64'(cdb_valid), 64'h0);
    tick();
    check("single_valid", 64'(cdb_valid), 64'h1);
    check("single_tag", 64'(cdb_tag[TAGW-1:0]), 64'd5);
    check("single_data", 64'(cdb_data[DATAW-1:0]), 64'hA5);
    check("single_pend_clr", 64'(pend), 64'h0);
    tick();
    check("single_one_pulse", 64'(cdb_valid), 64'h0);

    // Drop: wr=0 on slot 3
    req_valid = 4'b1000;
    req_wr    = 4'b0000;
    set_req(3, 5'd30, 32'h33);
    check("drop_ready", 64'(req_ready[3]), 64'h1);
    tick();
    req_valid = '0;
    check("drop_pend", 64'(pend), 64'h0);
    tick();
    check("drop_no_cdb", 64'(cdb_valid), 64'h0);

    // Back-to-back on slot 0: tags 1, 2, 3
    req_valid = 4'b0001;
    req_wr    = 4'b0001;
    set_req(0, 5'd1, 32'h1001);
    check("b2b_ready1", 64'(req_ready[0]), 64'h1);
    tick();
    set_req(0, 5'd2, 32'h1002);
    check("b2b_ready2", 64'(req_ready[0]), 64'h1);
    tick();
    check("b2b_valid1", 64'(cdb_valid), 64'h1);
    check("b2b_tag1", 64'(cdb_tag[TAGW-1:0]), 64'd1);
    set_req(0, 5'd3, 32'h1003);
    check("b2b_ready3", 64'(req_ready[0]), 64'h1);
    tick();
    req_valid = '0;
    check("b2b_valid2", 64'(cdb_valid), 64'h1);
    check("b2b_tag2", 64'(cdb_tag[TAGW-1:0]), 64'd2);
    tick();
    check("b2b_valid3", 64'(cdb_valid), 64'h1);
    check("b2b_tag3", 64'(cdb_tag[TAGW-1:0]), 64'd3);
    check("b2b_data3", 64'(cdb_data[DATAW-1:0]), 64'h1003);
    tick();
    check("b2b_end", 64'(cdb_valid), 64'h0);

    // Flush with slots 1 and 2 pending; slot 3 accept in the flush cycle is dropped
    req_valid = 4'b0110;
    req_wr    = 4'b0110;
    set_req(1, 5'd20, 32'h20);
    set_req(2, 5'd21, 32'h21);
    tick();
    check("fl_pend_before", 64'(pend), 64'h6);
    flush     = 1'b1;
    req_valid = 4'b1000;
    req_wr    = 4'b1000;
    set_req(3, 5'd22, 32'h22);
    check("fl_ready", 64'(req_ready), 64'hF);
    tick();
    flush     = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    check("fl_pend", 64'(pend), 64'h0);
    check("fl_cdb_valid", 64'(cdb_valid), 64'h0);
    tick();
    check("fl_cdb_valid_next", 64'(cdb_valid), 64'h0);

    // Bring rr_ptr back to 0
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    tick();

    // Four-way collision at rr_ptr=0
    req_valid = 4'b1111;
    req_wr    = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, TAGW'(16 + i), DATAW'(32'h100 + i));
    tick();
    req_valid = '0;
    check("col_pend", 64'(pend), 64'hF);
    check("col_ready", 64'(req_ready), 64'h3);
    tick();
    check("col1_valid", 64'(cdb_valid), 64'h3);
    check("col1_tag0", 64'(cdb_tag[TAGW-1:0]), 64'd16);
    check("col1_tag1", 64'(cdb_tag[2*TAGW-1:TAGW]), 64'd17);
    check("col1_data1", 64'(cdb_data[2*DATAW-1:DATAW]), 64'h101);
    check("col1_pend", 64'(pend), 64'hC);
    tick();
    check("col2_valid", 64'(cdb_valid), 64'h3);
    check("col2_tag0", 64'(cdb_tag[TAGW-1:0]), 64'd18);
    check("col2_tag1", 64'(cdb_tag[2*TAGW-1:TAGW]), 64'd19);
    check("col2_pend", 64'(pend), 64'h0);
    tick();
    check("col_end", 64'(cdb_valid), 64'h0);

    // Fairness: slots 0,1,2 request continuously from rr_ptr=0
    exp0 = '{0, 2, 1, 0, 2, 1};
    exp1 = '{1, 0, 2, 1, 0, 2};
    req_valid = 4'b0111;
    req_wr    = 4'b0111;
    for (int i = 0; i < 3; i++) set_req(i, TAGW'(8 + i), DATAW'(32'h200 + i));
    tick();
    check("fair_ready", 64'(req_ready), 64'hB);
    for (int n = 0; n < 6; n++) begin
      tick();
      check($sformatf("fair%0d_valid", n), 64'(cdb_valid), 64'h3);
      check($sformatf("fair%0d_tag0", n), 64'(cdb_tag[TAGW-1:0]), 64'(8 + exp0[n]));
      check($sformatf("fair%0d_tag1", n), 64'(cdb_tag[2*TAGW-1:TAGW]), 64'(8 + exp1[n]));
    end
    req_valid = '0;
    req_wr    = '0;
    tick();
    tick();
    tick();
    check("fair_drain", 64'(pend), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
